// File: rtl/demux_sel_sequencer_if.sv
// demux_sel_sequencer_if: command handshake and demux-drive bundle for demux_sel_sequencer
interface demux_sel_sequencer_if #(
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [1:0]                    cmd_ch;
  logic [LEN_W-1:0]              cmd_len;
  logic                          enable;
  logic [1:0]                    sig;
  logic                          done;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   level;
  modport master (
    output cmd_valid, cmd_ch, cmd_len,
    input  cmd_ready, enable, sig, done, busy, level
  );
  modport slave (
    input  cmd_valid, cmd_ch, cmd_len,
    output cmd_ready, enable, sig, done, busy, level
  );
endinterface

// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer: FIFO-buffered {channel,length} commands played out as enable bursts
module demux_sel_sequencer #(
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  demux_sel_sequencer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [3:0] GLOAD = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  state_t state, nstate;
  logic [LEN_W+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] level;
  logic [LEN_W-1:0] cnt;
  logic [3:0] gcnt;
  logic enable_d, done_d;
  logic [1:0] sig_d;
  logic push, pop, empty;
  logic [LEN_W-1:0] head_len;
  logic [1:0] head_ch;
  assign empty = level == '0;
  assign bus.cmd_ready = !rst && level != LW'(FIFO_DEPTH);
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop = state == IDLE && !empty;
  assign {head_ch, head_len} = mem[rp];
  assign bus.level = level;
  assign bus.busy = !empty || state != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {bus.cmd_ch, bus.cmd_len};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      level <= '0;
      cnt <= '0;
      gcnt <= '0;
      bus.enable <= 1'b0;
      bus.sig <= 2'b00;
      bus.done <= 1'b0;
    end else begin
      state <= nstate;
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (push && !pop) level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
      cnt <= pop ? head_len : (state == RUN) ? cnt - LEN_W'(1) : cnt;
      gcnt <= (nstate == GAP && state != GAP) ? GLOAD : (state == GAP) ? gcnt - 4'd1 : gcnt;
      bus.enable <= enable_d;
      bus.sig <= sig_d;
      bus.done <= done_d;
    end
  end
  // RUN is only entered with cnt>=1, so cnt==1 marks the last enable cycle
  always_comb
    nstate = (state == IDLE) ? (empty ? IDLE : (head_len == '0) ? GAP : RUN)
           : (state == RUN)  ? ((cnt == LEN_W'(1)) ? GAP : RUN)
           : ((gcnt == 4'd0) ? IDLE : GAP);
  // sig only reloads when a burst starts, so it never moves under enable or in IDLE
  always_comb begin
    enable_d = nstate == RUN;
    done_d = nstate == GAP && state != GAP;
    sig_d = (state == IDLE && nstate == RUN) ? head_ch : bus.sig;
  end
endmodule

// File: tb/tb_demux_sel_sequencer.sv
// tb_demux_sel_sequencer: vector table for per-cycle behaviour plus a FIFO-full burst sequence
module tb_demux_sel_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  demux_sel_sequencer_if #(.LEN_W(4), .FIFO_DEPTH(4)) bus ();
  demux_sel_sequencer #(.LEN_W(4), .FIFO_DEPTH(4), .GAP_CYCLES(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst, v;
    logic [1:0] ch;
    logic [3:0] len;
    logic rdy, en;
    logic [1:0] sg;
    logic dn, bsy;
    logic [2:0] lvl;
  } vec_t;
  vec_t tv [26];
  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask
  int pushed, nb, ndone, maxlvl, sig_err;
  int blen [8];
  logic [1:0] bsig [8];
  logic pe, acc;
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_ch = 2'd0;
    bus.cmd_len = 4'd0;
    //         rst v ch len   rdy en sg dn bsy lvl
    tv[0]  = '{1, 0, 0, 0,    0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 1, 2, 3,    1, 0, 0, 0, 1, 1};
    tv[2]  = '{0, 0, 0, 0,    1, 1, 2, 0, 1, 0};
    tv[3]  = '{0, 0, 0, 0,    1, 1, 2, 0, 1, 0};
    tv[4]  = '{0, 0, 0, 0,    1, 1, 2, 0, 1, 0};
    tv[5]  = '{0, 0, 0, 0,    1, 0, 2, 1, 1, 0};
    tv[6]  = '{0, 0, 0, 0,    1, 0, 2, 0, 0, 0};
    tv[7]  = '{0, 1, 1, 2,    1, 0, 2, 0, 1, 1};
    tv[8]  = '{0, 1, 3, 1,    1, 1, 1, 0, 1, 1};
    tv[9]  = '{0, 0, 0, 0,    1, 1, 1, 0, 1, 1};
    tv[10] = '{0, 0, 0, 0,    1, 0, 1, 1, 1, 1};
    tv[11] = '{0, 0, 0, 0,    1, 0, 1, 0, 1, 1};
    tv[12] = '{0, 0, 0, 0,    1, 1, 3, 0, 1, 0};
    tv[13] = '{0, 0, 0, 0,    1, 0, 3, 1, 1, 0};
    tv[14] = '{0, 0, 0, 0,    1, 0, 3, 0, 0, 0};
    tv[15] = '{0, 1, 0, 0,    1, 0, 3, 0, 1, 1};
    tv[16] = '{0, 0, 0, 0,    1, 0, 3, 1, 1, 0};
    tv[17] = '{0, 0, 0, 0,    1, 0, 3, 0, 0, 0};
    tv[18] = '{0, 1, 1, 10,   1, 0, 3, 0, 1, 1};
    tv[19] = '{0, 0, 0, 0,    1, 1, 1, 0, 1, 0};
    tv[20] = '{0, 0, 0, 0,    1, 1, 1, 0, 1, 0};
    tv[21] = '{1, 0, 0, 0,    0, 0, 0, 0, 0, 0};
    tv[22] = '{1, 1, 3, 5,    0, 0, 0, 0, 0, 0};
    tv[23] = '{1, 0, 0, 0,    0, 0, 0, 0, 0, 0};
    tv[24] = '{0, 0, 0, 0,    1, 0, 0, 0, 0, 0};
    tv[25] = '{0, 0, 0, 0,    1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      rst = tv[i].rst;
      bus.cmd_valid = tv[i].v;
      bus.cmd_ch = tv[i].ch;
      bus.cmd_len = tv[i].len;
      @(posedge clk);
      #1;
      chk("ready", i, int'(bus.cmd_ready), int'(tv[i].rdy));
      chk("enable", i, int'(bus.enable), int'(tv[i].en));
      chk("sig", i, int'(bus.sig), int'(tv[i].sg));
      chk("done", i, int'(bus.done), int'(tv[i].dn));
      chk("busy", i, int'(bus.busy), int'(tv[i].bsy));
      chk("level", i, int'(bus.level), int'(tv[i].lvl));
    end
    pushed = 0; nb = 0; ndone = 0; maxlvl = 0; sig_err = 0; pe = 1'b0;
    for (int c = 0; c < 200 && !(pushed == 5 && ndone == 5 && !bus.busy); c++) begin
      @(negedge clk);
      bus.cmd_valid = pushed < 5;
      bus.cmd_ch = 2'(pushed % 4);
      bus.cmd_len = 4'd15;
      acc = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        pushed++;
        if (pushed == 5) begin
          chk("t4_level_full", pushed, int'(bus.level), 4);
          chk("t4_ready_full", pushed, int'(bus.cmd_ready), 0);
        end
      end
      if (int'(bus.level) > maxlvl) maxlvl = int'(bus.level);
      if (bus.done) ndone++;
      if (bus.enable && !pe && nb < 8) begin
        bsig[nb] = bus.sig;
        blen[nb] = 1;
        nb++;
      end else if (bus.enable && nb > 0) begin
        blen[nb-1]++;
        if (bus.sig != bsig[nb-1]) sig_err++;
      end
      pe = bus.enable;
    end
    bus.cmd_valid = 1'b0;
    chk("t4_pushed", 0, pushed, 5);
    chk("t4_bursts", 0, nb, 5);
    chk("t4_dones", 0, ndone, 5);
    chk("t4_max_level", 0, maxlvl, 4);
    chk("t4_sig_stable", 0, sig_err, 0);
    chk("t4_idle", 0, int'(bus.busy), 0);
    for (int k = 0; k < 5 && k < nb; k++) begin
      chk("t4_burst_len", k, blen[k], 15);
      chk("t4_burst_sig", k, int'(bsig[k]), k % 4);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
